// File: rtl/dual_rail_pkg.sv
// -----------------------------------------------------------------------------
// dual_rail_pkg
// Shared types and helpers for the dual-rail (true/complement) transmitter.
//   dr_state_e      : transmitter FSM states (IDLE, DATA, SPACER)
//   dr_rails_t      : a {t, f} rail pair, sized for up to DR_MAX_W variables
//   DR_SPACER_CODE  : the all-zero spacer rail pair
//   dr_encode()     : single-rail word -> {rail_t, rail_f} codeword
//   dr_has_illegal(): flags any variable whose rails are both high (11 code)
// -----------------------------------------------------------------------------
package dual_rail_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        SPACER = 2'd2
    } dr_state_e;

    // Widest word the helpers handle; users slice the low WIDTH bits.
    localparam int DR_MAX_W = 32;

    typedef struct packed {
        logic [DR_MAX_W-1:0] t;
        logic [DR_MAX_W-1:0] f;
    } dr_rails_t;

    localparam dr_rails_t DR_SPACER_CODE = '0;

    // Bits at or above 'width' are left at zero on both rails so they read as spacer.
    function automatic dr_rails_t dr_encode(input logic [DR_MAX_W-1:0] word,
                                            input int                  width);
        dr_rails_t           r;
        logic [DR_MAX_W-1:0] mask;
        if (width >= DR_MAX_W) begin
            mask = '1;
        end else begin
            mask = (DR_MAX_W'(1) << width) - DR_MAX_W'(1);
        end
        r.t = word & mask;
        r.f = ~word & mask;
        return r;
    endfunction

    function automatic logic dr_has_illegal(input logic [DR_MAX_W-1:0] t,
                                            input logic [DR_MAX_W-1:0] f);
        return |(t & f);
    endfunction

endpackage

// File: rtl/dual_rail_tx_ack_sync.sv
// -----------------------------------------------------------------------------
// ack_sync
// Two-flop synchroniser bringing the receiver's completion-detect acknowledge
// into the clk domain. Both flops reset asynchronously to 0.
//   clk     in  : clock
//   rst_n   in  : asynchronous active-low reset
//   async_i in  : raw acknowledge, asynchronous to clk
//   sync_o  out : synchronised acknowledge (ack_s)
// -----------------------------------------------------------------------------
module ack_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic async_i,
    output logic sync_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= async_i;
            sync_q <= meta_q;
        end
    end

    assign sync_o = sync_q;

endmodule

// File: rtl/dual_rail_tx.sv
// -----------------------------------------------------------------------------
// dual_rail_tx
// Dual-rail four-phase transmitter: takes a single-rail word over valid/ready
// and drives it as a complete true/complement codeword, then returns to the
// all-zero spacer, paced by the receiver's completion-detect acknowledge.
//
// Parameters:
//   WIDTH          : encoded variables (1..32)
//   SPACER_CYCLES  : minimum spacer hold before the next codeword (1..15)
//   TIMEOUT_CYCLES : acknowledge watchdog limit (only with the macro below)
// Ports:
//   clk, rst_n           : clock, asynchronous active-low reset
//   in_valid/in_ready    : input handshake, in_data is the word to send
//   rail_t / rail_f      : true / complement rails (registered)
//   ack                  : receiver completion detect (asynchronous)
//   busy                 : high whenever the FSM is not in IDLE
//   tx_done              : one-cycle pulse at the end of a four-phase cycle
//   err                  : sticky acknowledge-timeout flag
// Build option:
//   DUAL_RAIL_ACK_TIMEOUT_EN : enables the acknowledge watchdog and err flag;
//                              when undefined err is tied low and the block
//                              waits on ack indefinitely.
// -----------------------------------------------------------------------------
module dual_rail_tx
    import dual_rail_pkg::*;
#(
    parameter int WIDTH          = 4,
    parameter int SPACER_CYCLES  = 1,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic [WIDTH-1:0] rail_t,
    output logic [WIDTH-1:0] rail_f,
    input  logic             ack,
    output logic             busy,
    output logic             tx_done,
    output logic             err
);

    localparam logic [3:0] SPC_LOAD = 4'(SPACER_CYCLES);

    logic             ack_s;
    dr_state_e        state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [WIDTH-1:0] rail_t_q, rail_t_d;
    logic [WIDTH-1:0] rail_f_q, rail_f_d;
    logic [3:0]       spc_q, spc_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [1:0]       prime_q;
    logic             blocked;
    dr_rails_t        enc;
    logic             unused_enc;

    ack_sync u_ack_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .async_i (ack),
        .sync_o  (ack_s)
    );

`ifdef DUAL_RAIL_ACK_TIMEOUT_EN
    localparam int             WD_W     = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT_CYCLES - 1);

    logic [WD_W-1:0] wd_q, wd_d;
    logic            err_q, err_d;

    assign blocked = err_q;
    assign err     = err_q;
`else
    assign blocked = 1'b0;
    assign err     = 1'b0;
`endif

    // prime_q holds acceptance off until the synchroniser has had two edges
    // to capture the real ack level, so an ack left high across reset is seen
    // before any word is taken. in_ready is decoded purely from flops.
    assign in_ready = prime_q[1] & (state_q == IDLE) & ~ack_s & ~blocked;

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        spc_d   = spc_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid && in_ready) begin
                    data_d  = in_data;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (ack_s) begin
                    state_d = SPACER;
                    spc_d   = SPC_LOAD;
                end
            end
            SPACER: begin
                // spc_q counts spacer cycles still owed, the current one included.
                if (spc_q > 4'd1) begin
                    spc_d = spc_q - 4'd1;
                end
                if (spc_q <= 4'd1 && !ack_s) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
`ifdef DUAL_RAIL_ACK_TIMEOUT_EN
        err_d = err_q;
        wd_d  = '0;
        if (state_q != IDLE) begin
            if (wd_q == WD_LIMIT) begin
                // Abort overrides any normal transition in the same cycle.
                state_d = IDLE;
                done_d  = 1'b0;
                err_d   = 1'b1;
            end else if (state_d == state_q) begin
                wd_d = wd_q + 1'b1;
            end
        end
`endif
    end

    // Rails follow the next state so they switch as one registered word:
    // either the full codeword or the spacer, never a mix.
    assign enc        = dr_encode(DR_MAX_W'(data_d), WIDTH);
    assign unused_enc = ^enc;

    always_comb begin
        rail_t_d = '0;
        rail_f_d = '0;
        if (state_d == DATA) begin
            rail_t_d = enc.t[WIDTH-1:0];
            rail_f_d = enc.f[WIDTH-1:0];
        end
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            data_q   <= '0;
            rail_t_q <= '0;
            rail_f_q <= '0;
            spc_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            prime_q  <= 2'b00;
        end else begin
            state_q  <= state_d;
            data_q   <= data_d;
            rail_t_q <= rail_t_d;
            rail_f_q <= rail_f_d;
            spc_q    <= spc_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            prime_q  <= {prime_q[0], 1'b1};
        end
    end

`ifdef DUAL_RAIL_ACK_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_q  <= '0;
            err_q <= 1'b0;
        end else begin
            wd_q  <= wd_d;
            err_q <= err_d;
        end
    end
`endif

    assign rail_t  = rail_t_q;
    assign rail_f  = rail_f_q;
    assign busy    = busy_q;
    assign tx_done = done_q;

endmodule
